cp0_irq_handler: RTL and testbench
==================================

// Module: cp0_irq_handler
// PURPOSE
//   Coprocessor-0 interrupt/exception receiver for the pipelined MIPS core. It is the consuming end of
//   the peripheral IRQ lines (timers and other bridge devices): it samples HWInt[7:2], masks them,
//   raises IntReq to the pipeline and commits exception entry (EXL, EPC, ExcCode).
//   It serves mfc0/mtc0 for SR(12), Cause(13), EPC(14) and PRId(15), and eret through EXLClr.
// PARAMETERS
//   PRID      32'h4D49_5053  value returned on a read of register 15 (read-only)
//   EPC_RST   32'h0000_3000  reset value of EPC
// PORTS
//   clk      in   1   system clock; every register updates on posedge
//   reset    in   1   asynchronous, active-high; clears all state immediately
//   A1       in   5   mfc0 read register number
//   A2       in   5   mtc0 write register number
//   DIn      in   32  mtc0 write data
//   We       in   1   mtc0 write enable (M stage)
//   PC       in   32  PC of the instruction in M stage (EPC candidate)
//   BD       in   1   M-stage instruction is in a branch delay slot
//   ExcReq   in   1   internal exception pending in M stage
//   ExcIn    in   5   ExcCode of the internal exception
//   HWInt    in   6   peripheral interrupt lines (bit0 = HWInt[2] = timer0)
//   EXLClr   in   1   eret in M stage
//   IntReq   out  1   take exception/interrupt now; pipeline flushes and redirects to 0x4180
//   EPC      out  32  current EPC register
//   DOut     out  32  mfc0 read data
// BEHAVIOUR
//   - Registers:
//     - SR: IM=[15:10], EXL=[1], IE=[0]; all other bits read 0 and ignore writes.
//     - Cause: BD=[31], IP=[15:10], ExcCode=[6:2]; all other bits read 0; Cause is not writable by mtc0.
//   - Reset (async): SR=0, Cause=0, EPC=EPC_RST, IntReq=0, DOut=PRID only when A1=15.
//   - IP sampling: Cause.IP <= HWInt on every posedge, regardless of EXL.
//     - Latency is 1 cycle: HWInt high at edge N gives IntReq at the earliest in cycle N+1.
//     - IP is a plain register sample, not a latch. A pulse shorter than 1 cycle can be lost.
//   - IntReq (combinational from registers and current inputs):
//     - HwReq  = IE & ~EXL & |(IM & IP)
//     - IntReq = HwReq | (ExcReq & ~EXL)
//   - Entry at a posedge with IntReq=1:
//     - EXL <= 1.
//     - BD <= BD input.
//     - EPC <= BD ? {PC[31:2]-1,2'b00} : {PC[31:2],2'b00}; EPC is always word-aligned.
//     - ExcCode <= HwReq ? 5'd0 : ExcIn. A hardware interrupt has priority over an internal exception.
//   - Exit at a posedge with EXLClr=1 and IntReq=0: EXL <= 0. SR.IM/IE and Cause are unchanged.
//   - mtc0 at a posedge with We=1 and IntReq=0:
//     - A2=12 writes IM and EXL/IE from the same DIn bit positions.
//     - A2=14 writes EPC <= {DIn[31:2],2'b00}.
//     - Writes to A2=13 and A2=15 are ignored.
//   - Simultaneous events:
//     - Entry beats everything else: IntReq=1 suppresses the We write and the EXLClr in that cycle.
//     - We to SR and EXLClr in the same cycle: the SR write is applied, then EXL is forced to 0.
//   - While EXL=1, IntReq stays 0 even with IP & IM != 0. Nested entry is impossible.
//   - Reads are combinational from the register values present before the edge; there is no
//     write-to-read bypass.
//     - A1 in {12,13,14,15} selects SR, Cause, EPC or PRID.
//     - Any other A1 returns 0.
//   - Reset mid-handler: EXL clears at once; any pending entry is dropped.
//   - Arithmetic: the EPC decrement is 30-bit and wraps modulo 2^30 (PC=0 with BD=1 gives 0xFFFF_FFFC).
// STRUCTURE
//   - cp0_pkg holds the shared constants:
//     - register numbers: SR=12, CAUSE=13, EPC=14, PRID=15;
//     - ExcCodes: INT=0, ADEL=4, ADES=5, RI=10, OV=12;
//     - SR/Cause bit-field positions;
//     - exception vector 32'h0000_4180.
//   - No sub-module; a single flat module of registers, the IntReq logic and the read mux.
// TESTING
//   1. Reset, then read A1=12/13/14/15:
//      -> 0, 0, 32'h0000_3000, PRID; IntReq=0.
//   2. mtc0 SR=32'h0000_0401 (IM[10]=1, IE=1), HWInt=6'b000001, PC=32'h0000_3010, BD=0:
//      -> IntReq=1 one cycle after the HWInt edge;
//      -> after the entry edge: EPC=32'h0000_3010, EXL=1, ExcCode=0, IntReq=0.
//   3. ExcReq=1, ExcIn=10, PC=32'h0000_3024, BD=1:
//      -> EPC=32'h0000_3020, Cause=32'h8000_0028, EXL=1.
//   4. HwReq and ExcReq (ExcIn=12) asserted in the same cycle:
//      -> ExcCode=0.
//   5. Entry cycle coinciding with We to A2=14 and EXLClr=1:
//      -> EPC equals PC, not DIn; EXL=1.
//      Then EXLClr alone -> EXL=0, and IntReq re-asserts if HWInt is still high.
//   6. Assert reset asynchronously between edges while EXL=1:
//      -> SR=0 and IntReq=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared constants for the coprocessor-0 interrupt/exception block:
// register numbers, exception codes, SR/Cause field positions and the vector.
package cp0_pkg;

  // mfc0/mtc0 register numbers served by this block
  typedef enum logic [4:0] {
    REG_SR    = 5'd12,
    REG_CAUSE = 5'd13,
    REG_EPC   = 5'd14,
    REG_PRID  = 5'd15
  } cp0_reg_e;

  // Exception codes written into Cause.ExcCode
  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  // SR field positions
  localparam int SR_IE     = 0;
  localparam int SR_EXL    = 1;
  localparam int SR_IM_LO  = 10;
  localparam int SR_IM_HI  = 15;

  // Cause field positions
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD     = 31;

  // Handler entry point the pipeline redirects to on IntReq
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

endpackage

// File: rtl/cp0_irq_handler.sv
// Coprocessor-0 interrupt/exception receiver: samples HWInt into Cause.IP,
// raises IntReq, commits exception entry (EXL/EPC/BD/ExcCode), handles eret
// via EXLClr and serves mfc0/mtc0 for SR, Cause, EPC and PRId.
import cp0_pkg::*;

module cp0_irq_handler #(
  parameter logic [31:0] PRID    = 32'h4D49_5053,
  parameter logic [31:0] EPC_RST = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        We,
  input  logic [31:0] PC,
  input  logic        BD,
  input  logic        ExcReq,
  input  logic [4:0]  ExcIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        IntReq,
  output logic [31:0] EPC,
  output logic [31:0] DOut
);

  logic [5:0]  im;
  logic        ie;
  logic        exl;
  logic [5:0]  ip;
  logic        cause_bd;
  logic [4:0]  exc_code;
  logic [31:0] epc_q;

  logic        hw_req;
  logic [31:0] epc_entry;
  logic [31:0] sr_word;
  logic [31:0] cause_word;
  logic [1:0]  unused_pc_bits;

  assign unused_pc_bits = PC[1:0];

  // Interrupt request: masked hardware lines or an internal exception, both blocked by EXL
  assign hw_req = ie & ~exl & (|(im & ip));
  assign IntReq = hw_req | (ExcReq & ~exl);

  // Delay-slot instructions resume at the branch; the 30-bit word decrement wraps
  assign epc_entry = BD ? {PC[31:2] - 30'd1, 2'b00} : {PC[31:2], 2'b00};

  assign sr_word    = {16'd0, im, 8'd0, exl, ie};
  assign cause_word = {cause_bd, 15'd0, ip, 3'd0, exc_code, 2'b00};
  assign EPC        = epc_q;

  // CP0 register state: IP sampling, exception entry, eret and mtc0 writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im       <= '0;
      ie       <= 1'b0;
      exl      <= 1'b0;
      ip       <= '0;
      cause_bd <= 1'b0;
      exc_code <= '0;
      epc_q    <= EPC_RST;
    end else begin
      ip <= HWInt;
      if (IntReq) begin
        exl      <= 1'b1;
        cause_bd <= BD;
        epc_q    <= epc_entry;
        exc_code <= hw_req ? EXC_INT : ExcIn;
      end else begin
        if (We && (A2 == REG_SR)) begin
          im  <= DIn[SR_IM_HI:SR_IM_LO];
          exl <= DIn[SR_EXL];
          ie  <= DIn[SR_IE];
        end
        if (We && (A2 == REG_EPC)) begin
          epc_q <= {DIn[31:2], 2'b00};
        end
        // NOTE: the last non-blocking assignment to a signal in a block wins,
        // so eret overrides an EXL value written by mtc0 in the same cycle.
        if (EXLClr) begin
          exl <= 1'b0;
        end
      end
    end
  end

  // mfc0 read mux from current register values (no write bypass)
  always_comb begin
    // NOTE: default first so every path assigns DOut and no latch is inferred.
    DOut = '0;
    case (A1)
      REG_SR:    DOut = sr_word;
      REG_CAUSE: DOut = cause_word;
      REG_EPC:   DOut = epc_q;
      REG_PRID:  DOut = PRID;
      default:   DOut = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_irq_handler.sv
// Self-checking bench for cp0_irq_handler: directed vector table, an
// asynchronous-reset sequence, and randomized traffic against a word-level model.
module tb_cp0_irq_handler;

  localparam logic [31:0] PRID_V    = 32'h4D49_5053;
  localparam logic [31:0] EPC_RST_V = 32'h0000_3000;

  logic        clk;
  logic        reset;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        We;
  logic [31:0] PC;
  logic        BD;
  logic        ExcReq;
  logic [4:0]  ExcIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        IntReq;
  logic [31:0] EPC;
  logic [31:0] DOut;

  int n_tests = 0;
  int n_fail  = 0;

  cp0_irq_handler #(.PRID(PRID_V), .EPC_RST(EPC_RST_V)) dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .We(We),
    .PC(PC), .BD(BD), .ExcReq(ExcReq), .ExcIn(ExcIn), .HWInt(HWInt),
    .EXLClr(EXLClr), .IntReq(IntReq), .EPC(EPC), .DOut(DOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  a2;
    logic [31:0] din;
    logic        exc_req;
    logic [4:0]  exc_in;
    logic [5:0]  hwint;
    logic        exlclr;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  a1;
    logic        int_exp;   // IntReq before the edge
    logic [31:0] dout_exp;  // DOut for a1 after the edge
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [4:0] a2, input logic [31:0] din,
                              input logic exc_req, input logic [4:0] exc_in, input logic [5:0] hwint,
                              input logic exlclr, input logic [31:0] pc, input logic bd,
                              input logic [4:0] a1, input logic int_exp, input logic [31:0] dout_exp);
    vec_t v;
    v.we = we; v.a2 = a2; v.din = din; v.exc_req = exc_req; v.exc_in = exc_in;
    v.hwint = hwint; v.exlclr = exlclr; v.pc = pc; v.bd = bd; v.a1 = a1;
    v.int_exp = int_exp; v.dout_exp = dout_exp;
    return v;
  endfunction

  task automatic drive_idle();
    A1 = 5'd0; A2 = 5'd0; DIn = '0; We = 1'b0; PC = '0; BD = 1'b0;
    ExcReq = 1'b0; ExcIn = '0; HWInt = '0; EXLClr = 1'b0;
  endtask

  // Word-level reference model state
  logic [31:0] m_sr, m_cause, m_epc;

  function automatic logic model_hw();
    return m_sr[0] && !m_sr[1] && ((m_sr[15:10] & m_cause[15:10]) != 6'd0);
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID_V;
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    logic [31:0] n_sr, n_cause, n_epc;
    logic        m_int;
    logic [4:0]  regs [5];

    drive_idle();
    reset = 1'b1;
    #12 reset = 1'b0;

    // Directed table, starting from reset state
    vecs.push_back(mk(0,  0, 0,            0,  0, 6'h00, 0, 0,            0, 12, 0, 32'h0000_0000));
    vecs.push_back(mk(0,  0, 0,            0,  0, 6'h00, 0, 0,            0, 13, 0, 32'h0000_0000));
    vecs.push_back(mk(0,  0, 0,            0,  0, 6'h00, 0, 0,            0, 14, 0, 32'h0000_3000));
    vecs.push_back(mk(0,  0, 0,            0,  0, 6'h00, 0, 0,            0, 15, 0, PRID_V));
    vecs.push_back(mk(1, 12, 32'h0000_0401, 0,  0, 6'h00, 0, 0,            0, 12, 0, 32'h0000_0401));
    vecs.push_back(mk(0,  0, 0,            0,  0, 6'h01, 0, 0,            0, 13, 0, 32'h0000_0400));
    vecs.push_back(mk(0,  0, 0,            0,  0, 6'h01, 0, 32'h0000_3010, 0, 14, 1, 32'h0000_3010));
    vecs.push_back(mk(0,  0, 0,            0,  0, 6'h01, 0, 0,            0, 12, 0, 32'h0000_0403));
    vecs.push_back(mk(0,  0, 0,            0,  0, 6'h00, 0, 0,            0, 13, 0, 32'h0000_0000));
    vecs.push_back(mk(0,  0, 0,            0,  0, 6'h00, 1, 0,            0, 12, 0, 32'h0000_0401));
    vecs.push_back(mk(0,  0, 0,            1, 10, 6'h00, 0, 32'h0000_3024, 1, 14, 1, 32'h0000_3020));
    vecs.push_back(mk(0,  0, 0,            0,  0, 6'h00, 0, 0,            0, 13, 0, 32'h8000_0028));
    vecs.push_back(mk(0,  0, 0,            0,  0, 6'h00, 0, 0,            0, 12, 0, 32'h0000_0403));
    vecs.push_back(mk(0,  0, 0,            0,  0, 6'h01, 1, 0,            0, 12, 0, 32'h0000_0401));
    vecs.push_back(mk(0,  0, 0,            1, 12, 6'h01, 0, 32'h0000_3040, 0, 13, 1, 32'h0000_0400));
    vecs.push_back(mk(0,  0, 0,            0,  0, 6'h01, 0, 0,            0, 12, 0, 32'h0000_0403));
    vecs.push_back(mk(0,  0, 0,            0,  0, 6'h01, 1, 0,            0, 12, 0, 32'h0000_0401));
    vecs.push_back(mk(1, 14, 32'h1234_5678, 0,  0, 6'h01, 1, 32'h0000_3050, 0, 14, 1, 32'h0000_3050));
    vecs.push_back(mk(0,  0, 0,            0,  0, 6'h01, 0, 0,            0, 12, 0, 32'h0000_0403));
    vecs.push_back(mk(0,  0, 0,            0,  0, 6'h01, 1, 0,            0, 12, 0, 32'h0000_0401));
    vecs.push_back(mk(0,  0, 0,            0,  0, 6'h01, 0, 0,            0, 12, 1, 32'h0000_0403));
    vecs.push_back(mk(0,  0, 0,            0,  0, 6'h00, 1, 0,            0, 14, 0, 32'h0000_0000));
    vecs.push_back(mk(0,  0, 0,            1,  4, 6'h00, 0, 32'h0000_0000, 1, 14, 1, 32'hFFFF_FFFC));
    vecs.push_back(mk(1, 14, 32'h1234_5677, 0,  0, 6'h00, 0, 0,            0, 14, 0, 32'h1234_5674));
    vecs.push_back(mk(1, 13, 32'hFFFF_FFFF, 0,  0, 6'h00, 0, 0,            0, 13, 0, 32'h8000_0010));
    vecs.push_back(mk(0,  0, 0,            0,  0, 6'h00, 0, 0,            0,  3, 0, 32'h0000_0000));

    foreach (vecs[i]) begin
      @(negedge clk);
      We = vecs[i].we; A2 = vecs[i].a2; DIn = vecs[i].din; ExcReq = vecs[i].exc_req;
      ExcIn = vecs[i].exc_in; HWInt = vecs[i].hwint; EXLClr = vecs[i].exlclr;
      PC = vecs[i].pc; BD = vecs[i].bd; A1 = vecs[i].a1;
      #1 check($sformatf("vec%0d IntReq", i), {31'd0, IntReq}, {31'd0, vecs[i].int_exp});
      @(posedge clk);
      #1 check($sformatf("vec%0d DOut", i), DOut, vecs[i].dout_exp);
    end

    // Asynchronous reset between edges while EXL=1 with IP&IM pending
    @(negedge clk);
    drive_idle();
    HWInt = 6'h01;
    A1 = 5'd12;
    #1 check("pre-reset SR", DOut, 32'h0000_0403);
    #1 reset = 1'b1;
    #1 check("async reset SR", DOut, 32'h0000_0000);
    check("async reset IntReq", {31'd0, IntReq}, 32'd0);
    check("async reset EPC", EPC, EPC_RST_V);
    A1 = 5'd13;
    #1 check("async reset Cause", DOut, 32'h0000_0000);
    @(negedge clk);
    reset = 1'b0;
    drive_idle();

    // Randomized traffic against the model
    m_sr = '0; m_cause = '0; m_epc = EPC_RST_V;
    regs[0] = 5'd12; regs[1] = 5'd13; regs[2] = 5'd14; regs[3] = 5'd15; regs[4] = 5'd7;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      A1     = regs[$urandom_range(0, 4)];
      A2     = ($urandom_range(0, 1) == 0) ? 5'd12 : regs[$urandom_range(0, 4)];
      DIn    = $urandom;
      We     = ($urandom_range(0, 2) == 0);
      PC     = $urandom;
      BD     = $urandom_range(0, 1) == 1;
      ExcReq = ($urandom_range(0, 5) == 0);
      ExcIn  = 5'($urandom_range(0, 31));
      HWInt  = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
      EXLClr = ($urandom_range(0, 3) == 0);
      #1;
      m_int = model_hw() || (ExcReq && !m_sr[1]);
      check($sformatf("rnd%0d IntReq", c), {31'd0, IntReq}, {31'd0, m_int});
      check($sformatf("rnd%0d DOut", c), DOut, model_read(A1));
      check($sformatf("rnd%0d EPC", c), EPC, m_epc);

      n_sr    = m_sr;
      n_epc   = m_epc;
      n_cause = (m_cause & ~32'h0000_FC00) | (32'(HWInt) << 10);
      if (m_int) begin
        n_sr    = m_sr | 32'h2;
        n_cause = (32'(BD) << 31) | (32'(HWInt) << 10) | (32'(model_hw() ? 5'd0 : ExcIn) << 2);
        n_epc   = (PC & ~32'h3) - (BD ? 32'd4 : 32'd0);
      end else begin
        if (We && A2 == 5'd12) n_sr = DIn & 32'h0000_FC03;
        if (We && A2 == 5'd14) n_epc = DIn & ~32'h3;
        if (EXLClr) n_sr = n_sr & ~32'h2;
      end
      @(posedge clk);
      m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
